// File: rtl/wifi_tx_fifo_pkg.sv
// Shared types and sizing helpers for the WIFI TX stream FIFO.
// Burst FSM encoding plus depth/count-width helpers derived from the address width.
package wifi_tx_fifo_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StPend  = 2'd2,
    StDrain = 2'd3
  } fifo_state_e;

  function automatic int unsigned fifo_depth(input int unsigned ad);
    return 32'd1 << ad;
  endfunction

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int unsigned fifo_cnt_w(input int unsigned ad);
    return ad + 32'd1;
  endfunction

endpackage

// File: rtl/wifi_tx_fifo_ram.sv
// Simple dual-port storage for the TX stream FIFO.
// Synchronous write, registered read on re_i; only the read register is reset.
module wifi_tx_fifo_ram #(
  parameter int unsigned DATA = 1,
  parameter int unsigned AD   = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            we_i,
  input  logic [AD-1:0]   waddr_i,
  input  logic [DATA-1:0] wdata_i,
  input  logic            re_i,
  input  logic [AD-1:0]   raddr_i,
  output logic [DATA-1:0] rdata_o
);

  logic [DATA-1:0] mem_q [2**AD];
  logic [DATA-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Holding the last word on idle cycles keeps data_out stable between beats.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wifi_tx_stream_fifo.sv
// Parametrised TX stream FIFO between scrambler/encoder and puncturer/interleaver, with a
// burst-tracking FSM for finished. Define WIFI_TX_FIFO_STATUS_EN to add level/ovf/udf ports.
module wifi_tx_stream_fifo
  import wifi_tx_fifo_pkg::*;
#(
  parameter int unsigned DATA  = 1,
  parameter int unsigned AD    = 4,
  parameter int unsigned AF_TH = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [DATA-1:0] data_in,
  input  logic            re,
  output logic [DATA-1:0] data_out,
  output logic            valid_out,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
`ifdef WIFI_TX_FIFO_STATUS_EN
  output logic [AD:0]     level,
  output logic            ovf,
  output logic            udf,
`endif
  output logic            finished
);

  localparam int unsigned Depth = fifo_depth(AD);
  localparam int unsigned CntW  = fifo_cnt_w(AD);
  localparam logic [CntW-1:0] DepthLvl = CntW'(Depth);
  localparam logic [CntW-1:0] LvlOne   = CntW'(1);
  localparam logic [AD-1:0]   PtrOne   = AD'(1);
  localparam bit              AfAlways = (AF_TH >= Depth);
  localparam logic [CntW-1:0] AfLvl    = AfAlways ? '0 : CntW'(Depth - AF_TH);

  logic            rd_ok, wr_ok;
  logic [AD-1:0]   wptr_d, wptr_q, rptr_d, rptr_q;
  logic [CntW-1:0] level_d, level_q;
  logic            full_d, full_q, empty_d, empty_q, af_d, af_q, valid_d, valid_q;
  fifo_state_e     state_d, state_q;
`ifdef WIFI_TX_FIFO_STATUS_EN
  logic            ovf_d, ovf_q, udf_d, udf_q;
`endif

  always_comb begin
    rd_ok   = re & ~empty_q;
    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    wr_ok   = we & (~full_q | rd_ok);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (wr_ok) wptr_d = wptr_q + PtrOne;
    if (rd_ok) rptr_d = rptr_q + PtrOne;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LvlOne;
      2'b01:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == DepthLvl);
    empty_d = (level_d == '0);
    af_d    = AfAlways | (level_d >= AfLvl);
    valid_d = rd_ok;
`ifdef WIFI_TX_FIFO_STATUS_EN
    ovf_d   = ovf_q | (we & full_q & ~rd_ok);
    udf_d   = udf_q | (re & empty_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (wr_ok) state_d = StLoad;
      StLoad:  if (!we) state_d = rd_ok ? StDrain : StPend;
      StPend:  if (rd_ok) state_d = StDrain;
      // Leave only once the final beat is on data_out and nothing new arrived.
      StDrain: if ((level_q == '0) && !rd_ok && !wr_ok && valid_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= AfAlways;
      valid_q <= 1'b0;
      state_q <= StIdle;
`ifdef WIFI_TX_FIFO_STATUS_EN
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
`endif
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      valid_q <= valid_d;
      state_q <= state_d;
`ifdef WIFI_TX_FIFO_STATUS_EN
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
`endif
    end
  end

  wifi_tx_fifo_ram #(
    .DATA (DATA),
    .AD   (AD)
  ) u_ram (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (wr_ok),
    .waddr_i (wptr_q),
    .wdata_i (data_in),
    .re_i    (rd_ok),
    .raddr_i (rptr_q),
    .rdata_o (data_out)
  );

  assign valid_out   = valid_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign finished    = (state_q == StIdle) || (state_q == StLoad);
`ifdef WIFI_TX_FIFO_STATUS_EN
  assign level       = level_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;
`endif

endmodule
